// File: rtl/fir_pkg.sv
// Shared constants and helpers for the FIR decimator slice.
package fir_pkg;

  localparam int SAMPLE_W = 16;

  // Ceiling log2, used for FIFO pointer and occupancy widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_decimator_if.sv
// Sample stream bundle between the FIR stage, the decimator and its consumer.
// master: the environment (FIR stage + consumer); slave: the decimator.
interface fir_decimator_if
  import fir_pkg::*;
#(
  parameter int N = SAMPLE_W
);

  logic         in_valid;
  logic [N-1:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] data_out;
  logic         overflow;

  modport master (
    output in_valid, data_in, out_ready,
    input  out_valid, data_out, overflow
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output out_valid, data_out, overflow
  );

endinterface

// File: rtl/fir_decimator_sync_fifo.sv
// First-word-fall-through FIFO. The head entry is visible on rdata while not
// empty; rdata reads as zero when empty so the output is clean after reset.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo
  import fir_pkg::*;
#(
  parameter int W     = SAMPLE_W,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic [W-1:0]        wdata,
  output logic [W-1:0]        rdata,
  output logic                full,
  output logic                empty,
  output logic [clog2(DEPTH):0] count
);

  localparam int PW = clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // Status flags and internal guards against overrun/underrun.
  always_comb begin
    full    = (count == DEPTH_C);
    empty   = (count == '0);
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    rdata   = empty ? '0 : mem[rd_ptr];
  end

  // Storage array; contents are only observable through valid entries.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fir_decimator.sv
// Integrate-and-dump decimator: averages each group of 2^LOG2_D valid input
// samples and queues the result in a small FWFT FIFO toward the consumer.
// Build option FIR_DECIM_ROUND_EN selects round-half-up instead of truncation.
module fir_decimator
  import fir_pkg::*;
#(
  parameter int N      = SAMPLE_W,
  parameter int LOG2_D = 2,
  parameter int DEPTH  = 4
) (
  input logic            clk,
  input logic            reset,
  fir_decimator_if.slave bus
);

  localparam int D  = 1 << LOG2_D;
  localparam int AW = N + LOG2_D;
  // Counter needs at least one bit even when LOG2_D = 0 (pass-through).
  localparam int CW = (LOG2_D > 0) ? LOG2_D : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(D - 1);
  localparam int PW = clog2(DEPTH);

  logic [AW-1:0] acc;
  logic [AW-1:0] sum;
  logic [AW-1:0] sum_adj;
  logic [CW-1:0] cnt;
  logic [N-1:0]  result;
  logic          group_done;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [PW:0]   fifo_count;
  logic          overflow_q;

  // Group sum, scaling and FIFO handshake gating.
  always_comb begin
    sum = acc + AW'(bus.data_in);
`ifdef FIR_DECIM_ROUND_EN
    // D/2 is zero when D = 1, so pass-through gets no rounding term.
    sum_adj = sum + AW'(D / 2);
`else
    sum_adj = sum;
`endif
    result        = N'(sum_adj >> LOG2_D);
    group_done    = bus.in_valid && (cnt == CNT_LAST);
    pop           = bus.out_ready && !empty;
    push          = group_done && (!full || pop);
    bus.out_valid = (fifo_count != '0);
    bus.overflow  = overflow_q;
  end

  // Accumulator and group counter advance on valid samples only; the counter
  // restarts even when the result is dropped so groups stay aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
    end else if (bus.in_valid) begin
      if (group_done) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Sticky flag: a completed result found the FIFO full with no pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (group_done && full && !pop) begin
      overflow_q <= 1'b1;
    end
  end

  sync_fifo #(
    .W     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (result),
    .rdata (bus.data_out),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

endmodule
